// File: rtl/ones_count_sched_if.sv
// Client and counter-side signals of the ones-counter scheduler.
// master = requesters plus counter, slave = scheduler.
interface ones_count_sched_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned ID_W  = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [CNT_W-1:0]        rsp_cnt;
  logic                    busy;
  logic                    cnt_start;
  logic [DATA_W-1:0]       cnt_data;
  logic                    cnt_rdy;
  logic [CNT_W-1:0]        cnt_result;

  modport master (
    output req, req_data, cnt_rdy, cnt_result,
    input  gnt, rsp_valid, rsp_id, rsp_cnt, busy, cnt_start, cnt_data
  );

  modport slave (
    input  req, req_data, cnt_rdy, cnt_result,
    output gnt, rsp_valid, rsp_id, rsp_cnt, busy, cnt_start, cnt_data
  );
endinterface

// File: rtl/ones_count_sched.sv
// Round-robin scheduler sharing one sequential ones-counter among N_REQ clients.
// One request in flight at a time; the result comes back tagged with the client id.
module ones_count_sched #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  ones_count_sched_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned ID_W  = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    win_sel;
  logic [ID_W-1:0]    idx;
  logic               win_found;
  logic               take;
  logic [DATA_W-1:0]  cnt_data_q;
  logic [CNT_W-1:0]   rsp_cnt_q;
  logic [DATA_W-1:0]  op [N_REQ];

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_op
    assign op[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // First active request at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % N_REQ);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_sel   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    bus.gnt   = '0;
    case (state)
      IDLE: begin
        if (bus.cnt_rdy && win_found) begin
          take      = 1'b1;
          bus.gnt   = N_REQ'(1) << win_sel;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:  if (!bus.cnt_rdy) state_nxt = RUN;
      RUN:     if (bus.cnt_rdy)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_id     <= '0;
      cnt_data_q <= '0;
      rsp_cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        win_id     <= win_sel;
        cnt_data_q <= op[win_sel];
      end
      if (state == RUN && bus.cnt_rdy) rsp_cnt_q <= bus.cnt_result;
      if (state == RESP) rr_ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  // Status and counter controls decode straight from the state register.
  assign bus.cnt_start = (state == LAUNCH);
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_id    = win_id;
  assign bus.rsp_cnt   = rsp_cnt_q;
  assign bus.cnt_data  = cnt_data_q;
endmodule

// File: tb/tb_ones_count_sched.sv
// Directed bench for ones_count_sched with a behavioural multi-cycle ones counter.
module tb_ones_count_sched;
  localparam int unsigned N_REQ = 4, DATA_W = 8, CNT_W = 4, RUN_LEN = 2;

  logic clk, rst, rdy_hold;
  ones_count_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();
  ones_count_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Counter model: drops rdy the edge after start is seen, returns after RUN_LEN+1 edges.
  logic              m_rdy;
  logic [CNT_W-1:0]  m_cnt;
  logic [DATA_W-1:0] m_data;
  int                m_timer;
  assign bus.cnt_rdy    = m_rdy & ~rdy_hold;
  assign bus.cnt_result = m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_rdy <= 1'b1; m_cnt <= '0; m_data <= '0; m_timer <= 0;
    end else if (m_rdy && bus.cnt_start) begin
      m_rdy <= 1'b0; m_data <= bus.cnt_data; m_timer <= RUN_LEN;
    end else if (!m_rdy) begin
      if (m_timer == 0) begin
        m_rdy <= 1'b1; m_cnt <= CNT_W'($countones(m_data));
      end else m_timer <= m_timer - 1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int i, input logic [DATA_W-1:0] d);
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic wait_gnt(output int waited, output bit to);
    waited = 0; to = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bus.gnt != '0) begin to = 1'b0; break; end
      tick(); #1; waited++;
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit to);
    cyc = 1; to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin to = 1'b0; break; end
      tick(); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_tests++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
    n_tests++; if (bus.rsp_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_rsp_cnt: got %0d want 0", bus.rsp_cnt); end
    n_tests++; if (bus.cnt_start !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_start: got %b want 0", bus.cnt_start); end
    n_tests++; if (bus.cnt_data !== 8'h00) begin n_fail++; $display("FAIL reset_cnt_data: got %h want 00", bus.cnt_data); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0; tick();
  endtask

  task automatic test_single();
    int w, cyc; bit to;
    set_lane(2, 8'hB5); bus.req = 4'b0100;
    wait_gnt(w, to);
    n_tests++; if (to || bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b timeout %0d want 0100", bus.gnt, to); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_gnt: got %b want 0", bus.busy); end
    tick(); bus.req = '0;
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b1 || bus.cnt_start !== 1'b1) begin n_fail++; $display("FAIL single_launch: busy %b start %b want 1 1", bus.busy, bus.cnt_start); end
    n_tests++; if (bus.cnt_data !== 8'hB5) begin n_fail++; $display("FAIL single_cnt_data: got %h want b5", bus.cnt_data); end
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd2 || bus.rsp_cnt !== 4'd5) begin n_fail++; $display("FAIL single_rsp: id %0d cnt %0d timeout %0d want id 2 cnt 5", bus.rsp_id, bus.rsp_cnt, to); end
    n_tests++; if (cyc !== 6) begin n_fail++; $display("FAIL single_latency: got %0d want 6", cyc); end
    n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_during_rsp: got %b want 0000", bus.gnt); end
    tick();
    n_tests++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: busy %b rsp_valid %b want 0 0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] ops [3];
    int exps [3];
    int w, cyc; bit to;
    ops = '{8'h00, 8'hFF, 8'h80};
    exps = '{0, 8, 1};
    for (int i = 0; i < 3; i++) begin
      set_lane(0, ops[i]); bus.req = 4'b0001;
      wait_gnt(w, to);
      tick(); bus.req = '0;
      wait_rsp(cyc, to);
      n_tests++; if (to || bus.rsp_id !== 2'd0 || bus.rsp_cnt !== CNT_W'(exps[i])) begin n_fail++; $display("FAIL boundary_%h: id %0d cnt %0d timeout %0d want id 0 cnt %0d", ops[i], bus.rsp_id, bus.rsp_cnt, to, exps[i]); end
      tick();
    end
  endtask

  // All four held high from reset: grants 0,1,2,3,0, each one cycle after the previous response.
  task automatic test_back_to_back();
    logic [1:0] ids [5];
    int cnts [5];
    int w, cyc; bit to;
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    cnts = '{1, 2, 3, 4, 1};
    set_lane(0, 8'h01); set_lane(1, 8'h03); set_lane(2, 8'h07); set_lane(3, 8'h0F);
    bus.req = 4'b1111; rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(w, to);
      n_tests++; if (to || bus.gnt !== (4'b0001 << ids[i])) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b want id %0d", i, bus.gnt, ids[i]); end
      n_tests++; if (w !== 0) begin n_fail++; $display("FAIL b2b_gap%0d: waited %0d want 0", i, w); end
      tick();
      if (i == 4) bus.req = '0;
      wait_rsp(cyc, to);
      n_tests++; if (to || bus.rsp_id !== ids[i] || bus.rsp_cnt !== CNT_W'(cnts[i])) begin n_fail++; $display("FAIL b2b_rsp%0d: id %0d cnt %0d want id %0d cnt %0d", i, bus.rsp_id, bus.rsp_cnt, ids[i], cnts[i]); end
      tick();
    end
  endtask

  task automatic test_rotation();
    int w, cyc; bit to;
    set_lane(3, 8'hF0); bus.req = 4'b1000;
    wait_gnt(w, to); tick(); bus.req = '0;
    wait_rsp(cyc, to); tick();
    set_lane(1, 8'h11); set_lane(3, 8'h77); bus.req = 4'b1010;
    wait_gnt(w, to);
    n_tests++; if (to || bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL rotation_first: got %b want 0010", bus.gnt); end
    tick(); bus.req = 4'b1000;
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd1 || bus.rsp_cnt !== 4'd2) begin n_fail++; $display("FAIL rotation_rsp1: id %0d cnt %0d want id 1 cnt 2", bus.rsp_id, bus.rsp_cnt); end
    tick();
    wait_gnt(w, to);
    n_tests++; if (to || bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL rotation_second: got %b want 1000", bus.gnt); end
    tick(); bus.req = '0;
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd3 || bus.rsp_cnt !== 4'd6) begin n_fail++; $display("FAIL rotation_rsp3: id %0d cnt %0d want id 3 cnt 6", bus.rsp_id, bus.rsp_cnt); end
    tick();
  endtask

  task automatic test_not_ready();
    int cyc; bit to; bit seen;
    rdy_hold = 1'b1; set_lane(0, 8'h3C); bus.req = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.gnt != '0) seen = 1'b1;
      tick();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL not_ready_gnt: grant seen %0d want 0", seen); end
    rdy_hold = 1'b0; #1;
    n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL not_ready_release: got %b want 0001", bus.gnt); end
    tick(); bus.req = '0;
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd0 || bus.rsp_cnt !== 4'd4) begin n_fail++; $display("FAIL not_ready_rsp: id %0d cnt %0d want id 0 cnt 4", bus.rsp_id, bus.rsp_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int w, cyc; bit to; bit seen;
    set_lane(2, 8'hFF); bus.req = 4'b0100;
    wait_gnt(w, to); tick(); bus.req = '0;
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy && !bus.cnt_start) begin to = 1'b0; break; end
      tick();
    end
    n_tests++; if (to) begin n_fail++; $display("FAIL midrun_reach_run: busy %b start %b want 1 0", bus.busy, bus.cnt_start); end
    rst = 1'b1; tick();
    n_tests++; if (bus.busy !== 1'b0 || bus.cnt_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: busy %b start %b rsp_valid %b want 0 0 0", bus.busy, bus.cnt_start, bus.rsp_valid); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_no_rsp: rsp_valid seen %0d want 0", seen); end
    // Pointer was 1 before reset; a cleared pointer picks client 0 first.
    set_lane(0, 8'h81); set_lane(1, 8'h0F); bus.req = 4'b0011;
    wait_gnt(w, to);
    n_tests++; if (to || bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrun_ptr_cleared: got %b want 0001", bus.gnt); end
    tick(); bus.req = 4'b0010;
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd0 || bus.rsp_cnt !== 4'd2) begin n_fail++; $display("FAIL midrun_rsp0: id %0d cnt %0d want id 0 cnt 2", bus.rsp_id, bus.rsp_cnt); end
    tick();
    wait_gnt(w, to);
    n_tests++; if (to || bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL midrun_gnt1: got %b want 0010", bus.gnt); end
    tick(); bus.req = '0;
    wait_rsp(cyc, to);
    n_tests++; if (to || bus.rsp_id !== 2'd1 || bus.rsp_cnt !== 4'd4) begin n_fail++; $display("FAIL midrun_rsp1: id %0d cnt %0d want id 1 cnt 4", bus.rsp_id, bus.rsp_cnt); end
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy_hold = 1'b0; bus.req = '0; bus.req_data = '0;
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_rotation();
    test_not_ready();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
